// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider (8-bit / 4-bit), one quotient bit per clock.
// Optional divide-by-zero flag and early exit under `DIVIDER_DZ_FLAG_EN`.
module seq_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
`ifdef DIVIDER_DZ_FLAG_EN
    output logic       dz,
`endif
    output logic [1:0] dbg_state
);

    // Handshake: start is a request sampled only in IDLE; done is a one-cycle
    // pulse with quotient/remainder valid, and busy covers RUN, DONE and the done cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [3:0]  rem_q, rem_d;
    logic [3:0]  div_q, div_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  quo_q, quo_d;
    logic [3:0]  remo_q, remo_d;
    logic        done_q, done_d;
`ifdef DIVIDER_DZ_FLAG_EN
    logic        dz_q, dz_d;
`endif

    logic [4:0]  p;
    logic [3:0]  diff;
    logic        ge;
    logic        qbit;

    // Trial subtract: low four bits of (p - divisor) only depend on p[3:0].
    always_comb begin
        p    = {rem_q, sr_q[7]};
        diff = p[3:0] - div_q;
        ge   = (p >= {1'b0, div_q});
        qbit = ge;
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rem_d   = rem_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        done_d  = 1'b0;
`ifdef DIVIDER_DZ_FLAG_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    div_d   = divisor;
                    sr_d    = dividend;
                    rem_d   = 4'd0;
                    cnt_d   = 3'd7;
                    state_d = RUN;
`ifdef DIVIDER_DZ_FLAG_EN
                    if (divisor == 4'd0) begin
                        state_d = DONE;
                        quo_d   = 8'hFF;
                        remo_d  = 4'h0;
                        dz_d    = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                rem_d = ge ? diff : p[3:0];
                sr_d  = {sr_q[6:0], qbit};
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    state_d = DONE;
                    quo_d   = sr_d;
                    remo_d  = rem_d;
`ifdef DIVIDER_DZ_FLAG_EN
                    dz_d    = 1'b0;
`endif
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= 8'd0;
            rem_q   <= 4'd0;
            div_q   <= 4'd0;
            cnt_q   <= 3'd0;
            quo_q   <= 8'd0;
            remo_q  <= 4'd0;
            done_q  <= 1'b0;
`ifdef DIVIDER_DZ_FLAG_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            done_q  <= done_d;
`ifdef DIVIDER_DZ_FLAG_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE) || done_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = remo_q;
    assign dbg_state = state_q;
`ifdef DIVIDER_DZ_FLAG_EN
    assign dz        = dz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: handshake timing, corner operands, ignore/reset
// behaviour, divide-by-zero and a back-to-back sweep of all nonzero divisors.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic [1:0] dbg_state;
`ifdef DIVIDER_DZ_FLAG_EN
    logic       dz;
`endif

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    seq_divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
`ifdef DIVIDER_DZ_FLAG_EN
        .dz        (dz),
`endif
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one accepted start; operands are scrambled right after the edge.
    task automatic start_op(input logic [7:0] a, input logic [3:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        start    = 1'b0;
        dividend = 8'($urandom_range(0, 255));
        divisor  = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er, input int elat);
        int lat;
        start_op(a, b);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        step();
        chk({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int k;
        int seen;
        int a;
        int b;
        bit fin;
        logic [11:0] e;

        rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
`ifdef DIVIDER_DZ_FLAG_EN
        chk("rst_dz", 32'(dz), 32'd0);
`endif
        rst = 1'b0;
        step();

        run_op("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 9);
        chk("d200_7_idle_busy", 32'(busy), 32'd0);
        run_op("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 9);
        run_op("d5_9", 8'd5, 4'd9, 8'd0, 4'd5, 9);
        run_op("d0_15", 8'd0, 4'd15, 8'd0, 4'd0, 9);

        // Second start during RUN cycle 3 must be dropped; outputs hold meanwhile.
        step();
        start_op(8'd100, 4'd3);
        chk("ign_hold_r", 32'(remainder), 32'd0);
        step();
        step();
        start = 1'b1; dividend = 8'd50; divisor = 4'd5;
        step();
        start = 1'b0;
        chk("ign_hold_q", 32'(quotient), 32'd0);
        wait_done(lat);
        chk("ign_lat", 32'(lat + 3), 32'd9);
        chk("ign_q", 32'(quotient), 32'd33);
        chk("ign_r", 32'(remainder), 32'd1);
        step();
        chk("ign_pulse", 32'(done), 32'd0);
        chk("ign_idle_busy", 32'(busy), 32'd0);

        // Reset in RUN cycle 5 of 77/6.
        start_op(8'd77, 4'd6);
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_q", 32'(quotient), 32'd0);
        chk("mid_rst_r", 32'(remainder), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) seen++;
        end
        chk("mid_rst_no_done", 32'(seen), 32'd0);
        run_op("d77_6", 8'd77, 4'd6, 8'd12, 4'd5, 9);

`ifdef DIVIDER_DZ_FLAG_EN
        run_op("dz_a3_0", 8'hA3, 4'd0, 8'hFF, 4'h0, 1);
        chk("dz_set", 32'(dz), 32'd1);
        run_op("dz_9_3", 8'd9, 4'd3, 8'd3, 4'd0, 9);
        chk("dz_clr", 32'(dz), 32'd0);
`else
        run_op("nodz_a3_0", 8'hA3, 4'd0, 8'hFF, 4'h3, 9);
        run_op("nodz_9_3", 8'd9, 4'd3, 8'd3, 4'd0, 9);
`endif

        // Back-to-back sweep: next start is driven during each done cycle.
        k = 0;
        fin = 1'b0;
        a = k / 15; b = k % 15 + 1;
        start = 1'b1; dividend = 8'(a); divisor = 4'(b);
        exp_q.push_back({8'(a / b), 4'(a % b)});
        step();
        start = 1'b0;
        k++;
        while (!fin) begin
            lat = 0;
            while (!done && lat < 20) begin
                step();
                lat++;
            end
            if (!done) begin
                chk("sweep_timeout", 32'(done), 32'd1);
                fin = 1'b1;
            end else begin
                e = exp_q.pop_front();
                chk("sweep_qr", 32'({quotient, remainder}), 32'(e));
                chk("sweep_lat", 32'(lat), 32'd9);
                if (k < 3840) begin
                    a = k / 15; b = k % 15 + 1;
                    start = 1'b1; dividend = 8'(a); divisor = 4'(b);
                    exp_q.push_back({8'(a / b), 4'(a % b)});
                    step();
                    start = 1'b0;
                    k++;
                end else begin
                    step();
                    fin = 1'b1;
                end
                chk("sweep_pulse", 32'(done), 32'd0);
            end
        end
        chk("sweep_busy_end", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
